arm_shift_pipe: RTL and testbench

Parametrised, pipelined operand-2 shifter for the ARM datapath. It is the next generation of the combinational shifter. It adds:
- full ARM shift semantics: immediate and register shift amounts, RRX, carry-out;
- rotated immediates and branch-offset scaling;
- a two-stage pipeline with valid/ready handshakes on both sides.

It sits between register read and the ALU. It feeds `result` as operand 2 and `carry_out` as the shifter carry flag.

---
 rtl/arm_shift_pipe_if.sv | 35 +++
 rtl/arm_shift_pipe.sv | 157 +++++++++++++++
 tb/tb_arm_shift_pipe.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/arm_shift_pipe_if.sv
// Request/response bundle for the pipelined operand-2 shifter.
// The master side issues requests and consumes results; the shifter is the slave.
interface arm_shift_pipe_if #(
  parameter int DATA_W = 32
);
  localparam int SH_W = $clog2(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [1:0]        shift_type;
  logic [DATA_W-1:0] rm_data;
  logic [SH_W-1:0]   shamt_imm;
  logic [7:0]        rs_amt;
  logic [7:0]        imm8;
  logic [3:0]        rot;
  logic [23:0]       br_off;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              carry_out;

  modport master (
    output in_valid, mode, shift_type, rm_data, shamt_imm, rs_amt,
           imm8, rot, br_off, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  in_valid, mode, shift_type, rm_data, shamt_imm, rs_amt,
           imm8, rot, br_off, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/arm_shift_pipe.sv
// Two-stage ARM operand-2 shifter. Stage 1 decodes the request into an
// operation plus a 9-bit effective amount; stage 2 computes result/carry and
// holds them as the output register until the consumer takes them.
module arm_shift_pipe #(
  parameter int DATA_W   = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic           clk,
  input  logic           reset,
  arm_shift_pipe_if.slave bus
);
  localparam int         SH_W = $clog2(DATA_W);
  localparam logic [8:0] W9   = 9'(DATA_W);

  typedef enum logic [2:0] {
    OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX, OP_ROTIMM, OP_BRANCH
  } op_t;

  op_t               d_op, s1_op;
  logic [8:0]        d_amt, s1_amt;
  logic [DATA_W-1:0] d_rm, s1_rm;
  logic              s1_cin, s1_valid, s1_adv;
  logic              s2_valid, s2_carry;
  logic [DATA_W-1:0] s2_result;

  logic [DATA_W-1:0] nx_result;
  logic              nx_carry;
  logic [DATA_W:0]   lsl_w, lsr_w;
  logic signed [DATA_W:0] asr_w;
  logic [8:0]        asr_n;
  logic [SH_W-1:0]   rot_n;
  logic [DATA_W-1:0] rot_v;

  assign s1_adv        = !s2_valid || bus.out_ready;
  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.carry_out = s2_carry;

  // Decode the request into an operation and effective amount. Amount 0 on
  // the LSL path means pass-through with the incoming carry.
  always_comb begin
    d_op  = OP_LSL;
    d_amt = '0;
    d_rm  = bus.rm_data;
    unique case (bus.mode)
      2'b00: begin
        d_amt = 9'(bus.shamt_imm);
        unique case (bus.shift_type)
          2'b00: d_op = OP_LSL;
          2'b01: begin
            d_op = OP_LSR;
            if (bus.shamt_imm == '0) d_amt = W9;
          end
          2'b10: begin
            d_op = OP_ASR;
            if (bus.shamt_imm == '0) d_amt = W9;
          end
          default: d_op = (bus.shamt_imm == '0) ? OP_RRX : OP_ROR;
        endcase
      end
      2'b01: begin
        d_amt = {1'b0, bus.rs_amt};
        if (bus.rs_amt == 8'd0) begin
          d_op = OP_LSL;
        end else begin
          unique case (bus.shift_type)
            2'b00:   d_op = OP_LSL;
            2'b01:   d_op = OP_LSR;
            2'b10:   d_op = OP_ASR;
            default: d_op = OP_ROR;
          endcase
        end
      end
      2'b10: begin
        d_op  = OP_ROTIMM;
        d_amt = {4'b0, bus.rot, 1'b0};
        d_rm  = DATA_W'(bus.imm8);
      end
      default: begin
        d_op = OP_BRANCH;
        d_rm = {{(DATA_W-24){bus.br_off[23]}}, bus.br_off};
      end
    endcase
  end

  // Stage-1 valid flag: refills whenever the stage is empty or moving on.
  always_ff @(posedge clk) begin
    if (reset)             s1_valid <= 1'b0;
    else if (bus.in_ready) s1_valid <= bus.in_valid;
  end

  // Stage-1 operand capture on an accepted request.
  always_ff @(posedge clk) begin
    if (bus.in_ready && bus.in_valid) begin
      s1_op  <= d_op;
      s1_amt <= d_amt;
      s1_rm  <= d_rm;
      s1_cin <= bus.carry_in;
    end
  end

  // Shift datapath. The extra bit on each wide shift catches the last bit
  // shifted out, which is the ARM carry for every amount including >= W.
  always_comb begin
    lsl_w = {1'b0, s1_rm} << s1_amt;
    lsr_w = {s1_rm, 1'b0} >> s1_amt;
    asr_n = (s1_amt > W9) ? W9 : s1_amt;
    asr_w = $signed({s1_rm, 1'b0}) >>> asr_n;
    rot_n = s1_amt[SH_W-1:0];
    rot_v = (s1_rm >> rot_n) | (s1_rm << (W9 - 9'(rot_n)));
    nx_result = s1_rm;
    nx_carry  = s1_cin;
    unique case (s1_op)
      OP_LSL: if (s1_amt != '0) begin
        nx_result = lsl_w[DATA_W-1:0];
        nx_carry  = lsl_w[DATA_W];
      end
      OP_LSR: if (s1_amt != '0) begin
        nx_result = lsr_w[DATA_W:1];
        nx_carry  = lsr_w[0];
      end
      OP_ASR: if (s1_amt != '0) begin
        nx_result = asr_w[DATA_W:1];
        nx_carry  = asr_w[0];
      end
      OP_ROR: if (s1_amt != '0) begin
        nx_result = rot_v;
        nx_carry  = rot_v[DATA_W-1];
      end
      OP_RRX: begin
        nx_result = {s1_cin, s1_rm[DATA_W-1:1]};
        nx_carry  = s1_rm[0];
      end
      OP_ROTIMM: begin
        nx_result = rot_v;
        nx_carry  = (s1_amt == '0) ? s1_cin : rot_v[DATA_W-1];
      end
      default: nx_result = s1_rm << BR_SHIFT;
    endcase
  end

  // Output register: loads when the consumer side frees it, holds on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= nx_result;
        s2_carry  <= nx_carry;
      end
    end
  end
endmodule

// File: tb/tb_arm_shift_pipe.sv
// Self-checking bench for arm_shift_pipe: directed cases, a stalled stream,
// random traffic against a bit-serial ARM shift model, and reset-in-stall.
module tb_arm_shift_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_emit = 0;
  logic last_acc = 1'b0;
  logic last_in_ready = 1'b0;
  logic [32:0] exp_q[$];
  logic [7:0]  rs_tab [10] = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd40, 8'd63, 8'd64, 8'd128, 8'd255};

  arm_shift_pipe_if #(.DATA_W(32)) bus ();
  arm_shift_pipe_if #(.DATA_W(64)) bus64 ();

  arm_shift_pipe #(.DATA_W(32), .BR_SHIFT(2)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  arm_shift_pipe #(.DATA_W(64), .BR_SHIFT(2)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64));

  always #5 clk = ~clk;

  // ARM shift semantics as one bit per step: the carry is the last bit moved out.
  function automatic logic [32:0] ref_model(input logic [1:0] mode, input logic [1:0] st,
      input logic [31:0] rm, input logic [4:0] sh, input logic [7:0] rs, input logic [7:0] imm,
      input logic [3:0] rot, input logic [23:0] br, input logic cin);
    logic [31:0] v;
    logic c;
    int n;
    int kind;
    v = rm; c = cin; n = 0; kind = int'(st);
    case (mode)
      2'd0: begin
        n = int'(sh);
        if (sh == 5'd0 && st == 2'd3) return {rm[0], cin, rm[31:1]};
        if (sh == 5'd0 && (st == 2'd1 || st == 2'd2)) n = 32;
      end
      2'd1: n = int'(rs);
      2'd2: begin v = {24'd0, imm}; kind = 3; n = 2 * int'(rot); end
      default: begin
        v = {{8{br[23]}}, br};
        return {cin, v * 32'd4};
      end
    endcase
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: begin c = v[31]; v = v << 1; end
        1: begin c = v[0];  v = v >> 1; end
        2: begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0]; v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: scoreboard accepts/emits, then verify output hold on stall.
  task automatic cycle();
    logic acc, emit, stall;
    logic [32:0] held;
    #2;
    acc   = bus.in_valid && bus.in_ready && !reset;
    emit  = bus.out_valid && bus.out_ready && !reset;
    stall = bus.out_valid && !bus.out_ready && !reset;
    held  = {bus.carry_out, bus.result};
    last_acc = acc;
    last_in_ready = bus.in_ready;
    if (acc) exp_q.push_back(ref_model(bus.mode, bus.shift_type, bus.rm_data, bus.shamt_imm,
                                       bus.rs_amt, bus.imm8, bus.rot, bus.br_off, bus.carry_in));
    if (emit) begin
      n_emit++;
      if (exp_q.size() == 0) check("unexpected_output", 65'(bus.out_valid), 65'(0));
      else check("stream_result", 65'({bus.carry_out, bus.result}), 65'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    if (reset) exp_q.delete();
    if (stall) begin
      check("stall_valid", 65'(bus.out_valid), 65'(1));
      check("stall_hold", 65'({bus.carry_out, bus.result}), 65'(held));
    end
  endtask

  task automatic set_req(input logic [1:0] mode, input logic [1:0] st, input logic [31:0] rm,
      input logic [4:0] sh, input logic [7:0] rs, input logic [7:0] imm, input logic [3:0] rot,
      input logic [23:0] br, input logic cin);
    bus.mode = mode; bus.shift_type = st; bus.rm_data = rm; bus.shamt_imm = sh;
    bus.rs_amt = rs; bus.imm8 = imm; bus.rot = rot; bus.br_off = br; bus.carry_in = cin;
  endtask

  task automatic rand_req();
    logic [31:0] rm;
    logic [4:0] sh;
    logic [7:0] rs;
    int k;
    k = int'($urandom_range(0, 3));
    rm = (k == 0) ? 32'h8000_0000 : (k == 1) ? 32'hFFFF_FFFF : $urandom;
    k = int'($urandom_range(0, 3));
    sh = (k == 0) ? 5'd0 : (k == 1) ? 5'd31 : 5'($urandom);
    k = int'($urandom_range(0, 11));
    rs = (k < 10) ? rs_tab[k] : 8'($urandom);
    set_req(2'($urandom), 2'($urandom), rm, sh, rs, 8'($urandom), 4'($urandom),
            24'($urandom), 1'($urandom));
  endtask

  // Single request with open output: fixed two-cycle latency and known answer.
  task automatic directed(input string tag, input logic [1:0] mode, input logic [1:0] st,
      input logic [31:0] rm, input logic [4:0] sh, input logic [7:0] rs, input logic [7:0] imm,
      input logic [3:0] rot, input logic [23:0] br, input logic cin,
      input logic [31:0] exp_r, input logic exp_c);
    set_req(mode, st, rm, sh, rs, imm, rot, br, cin);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    check({tag, "_accept"}, 65'(last_acc), 65'(1));
    bus.in_valid = 1'b0;
    check({tag, "_early"}, 65'(bus.out_valid), 65'(0));
    cycle();
    check({tag, "_latency"}, 65'(bus.out_valid), 65'(1));
    check({tag, "_value"}, 65'({bus.carry_out, bus.result}), 65'({exp_c, exp_r}));
    cycle();
  endtask

  task automatic directed64(input string tag, input logic [1:0] mode, input logic [1:0] st,
      input logic [63:0] rm, input logic [23:0] br, input logic cin,
      input logic [63:0] exp_r, input logic exp_c);
    bus64.mode = mode; bus64.shift_type = st; bus64.rm_data = rm; bus64.br_off = br;
    bus64.carry_in = cin; bus64.shamt_imm = 6'd0; bus64.in_valid = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, 65'(bus64.out_valid), 65'(1));
    check({tag, "_value"}, {bus64.carry_out, bus64.result}, {exp_c, exp_r});
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    int base;
    logic saw_block;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_req(2'd0, 2'd0, 32'd0, 5'd0, 8'd0, 8'd0, 4'd0, 24'd0, 1'b0);
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.mode = 2'd0; bus64.shift_type = 2'd0;
    bus64.rm_data = '0; bus64.shamt_imm = '0; bus64.rs_amt = '0; bus64.imm8 = '0;
    bus64.rot = '0; bus64.br_off = '0; bus64.carry_in = 1'b0;

    cycle(); cycle();
    reset = 1'b0;
    check("reset_out_valid", 65'(bus.out_valid), 65'(0));
    check("reset_value", 65'({bus.carry_out, bus.result}), 65'(0));
    check("reset_in_ready", 65'(bus.in_ready), 65'(1));

    directed("lsl4",      2'd0, 2'd0, 32'h0000_0001, 5'd4, 8'd0,  8'd0,  4'd0, 24'd0, 1'b1, 32'h0000_0010, 1'b0);
    directed("rrx",       2'd0, 2'd3, 32'h0000_0003, 5'd0, 8'd0,  8'd0,  4'd0, 24'd0, 1'b1, 32'h8000_0001, 1'b1);
    directed("lsr_imm0",  2'd0, 2'd1, 32'h0000_0003, 5'd0, 8'd0,  8'd0,  4'd0, 24'd0, 1'b1, 32'h0000_0000, 1'b0);
    directed("asr_imm0",  2'd0, 2'd2, 32'h8000_0000, 5'd0, 8'd0,  8'd0,  4'd0, 24'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    directed("asr_r40",   2'd1, 2'd2, 32'h8000_0000, 5'd0, 8'd40, 8'd0,  4'd0, 24'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    directed("lsl_r32",   2'd1, 2'd0, 32'h8000_0000, 5'd0, 8'd32, 8'd0,  4'd0, 24'd0, 1'b1, 32'h0000_0000, 1'b0);
    directed("ror_r32",   2'd1, 2'd3, 32'h8000_0000, 5'd0, 8'd32, 8'd0,  4'd0, 24'd0, 1'b0, 32'h8000_0000, 1'b1);
    directed("lsr_r0",    2'd1, 2'd1, 32'h8000_0000, 5'd0, 8'd0,  8'd0,  4'd0, 24'd0, 1'b1, 32'h8000_0000, 1'b1);
    directed("lsr_r32",   2'd1, 2'd1, 32'h8000_0000, 5'd0, 8'd32, 8'd0,  4'd0, 24'd0, 1'b0, 32'h0000_0000, 1'b1);
    directed("lsl_r33",   2'd1, 2'd0, 32'hFFFF_FFFF, 5'd0, 8'd33, 8'd0,  4'd0, 24'd0, 1'b1, 32'h0000_0000, 1'b0);
    directed("rotimm8",   2'd2, 2'd1, 32'h0,         5'd0, 8'd0,  8'hFF, 4'd4, 24'd0, 1'b0, 32'hFF00_0000, 1'b1);
    directed("rotimm0",   2'd2, 2'd0, 32'h0,         5'd0, 8'd0,  8'h5A, 4'd0, 24'd0, 1'b1, 32'h0000_005A, 1'b1);
    directed("branch_neg",2'd3, 2'd2, 32'h0,         5'd0, 8'd0,  8'd0,  4'd0, 24'hFFFFFE, 1'b0, 32'hFFFF_FFF8, 1'b0);

    directed64("br64",  2'd3, 2'd0, 64'd0, 24'h000010, 1'b1, 64'h40, 1'b1);
    directed64("asr64", 2'd0, 2'd2, 64'h8000_0000_0000_0000, 24'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Six back-to-back requests with a three-cycle output stall mid-stream.
    sent = 0; base = n_emit; saw_block = 1'b0;
    rand_req();
    for (int k = 0; k < 40 && (n_emit - base) < 6; k++) begin
      bus.in_valid = (sent < 6);
      bus.out_ready = !(k >= 3 && k < 6);
      cycle();
      if (bus.in_valid && !last_in_ready) saw_block = 1'b1;
      if (last_acc) begin sent++; rand_req(); end
    end
    check("stream_count", 65'(n_emit - base), 65'(6));
    check("stream_backpressure", 65'(saw_block), 65'(1));
    check("stream_drained", 65'(exp_q.size()), 65'(0));

    // Random traffic with random consumer stalls, then drain.
    for (int k = 0; k < 600; k++) begin
      rand_req();
      bus.in_valid = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
    check("random_drained", 65'(exp_q.size()), 65'(0));

    // Fill both stages under stall, then reset.
    bus.out_ready = 1'b0;
    rand_req(); bus.in_valid = 1'b1; cycle();
    rand_req(); cycle();
    bus.in_valid = 1'b0;
    check("full_out_valid", 65'(bus.out_valid), 65'(1));
    check("full_in_ready", 65'(bus.in_ready), 65'(0));
    reset = 1'b1;
    cycle();
    check("rst_stall_out_valid", 65'(bus.out_valid), 65'(0));
    check("rst_stall_value", 65'({bus.carry_out, bus.result}), 65'(0));
    check("rst_stall_in_ready", 65'(bus.in_ready), 65'(1));
    reset = 1'b0;
    directed("after_reset", 2'd1, 2'd1, 32'hF000_000F, 5'd0, 8'd4, 8'd0, 4'd0, 24'd0, 1'b0, 32'h0F00_0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
